// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single DataMemory port: IDLE/ACCESS/RESP FSM with round-robin or fixed priority.
// Optional grant/conflict statistics counters are compiled in when ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int ACCESS_CYCLES  = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [1:0]  m0_mode,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [1:0]  m1_mode,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic [1:0]  mem_mode,
    output logic        mem_memRead,
    output logic        mem_memWrite,
    input  logic [31:0] mem_readData,
    output logic        busy,
    output logic        owner
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] stat_m0_grants,
    output logic [15:0] stat_m1_grants,
    output logic [15:0] stat_conflicts
`endif
);

    generate
        if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : gBadAccessCycles
            $error("dmem_arbiter: ACCESS_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      nextState;
    logic        lastOwner;
    logic [3:0]  cnt;
    logic        latWrite;
    logic [1:0]  latMode;
    logic [31:0] latAddr;
    logic [31:0] latWdata;
    logic        anyReq;
    logic        bothReq;
    logic        winner;
    logic        grant;

    // Winner: a lone requester wins; on conflict either m0 (fixed) or whoever did not go last.
    always_comb begin
        anyReq  = m0_req | m1_req;
        bothReq = m0_req & m1_req;
        if (bothReq)
            winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~lastOwner;
        else
            winner = ~m0_req;
        grant = (state == IDLE) && anyReq;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState     = state;
        busy          = 1'b0;
        m0_ready      = 1'b0;
        m1_ready      = 1'b0;
        mem_address   = 32'd0;
        mem_writeData = 32'd0;
        mem_mode      = 2'd0;
        mem_memRead   = 1'b0;
        mem_memWrite  = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq)
                    nextState = ACCESS;
            end
            ACCESS: begin
                busy          = 1'b1;
                mem_address   = latAddr;
                mem_writeData = latWdata;
                mem_mode      = latMode;
                mem_memRead   = ~latWrite;
                // A store gets exactly one write edge, at the end of the access window.
                mem_memWrite  = latWrite && (cnt == 4'd0);
                if (cnt == 4'd0)
                    nextState = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                m0_ready  = ~owner;
                m1_ready  = owner;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= 1'b0;
            lastOwner <= 1'b1;
            cnt       <= 4'd0;
            latWrite  <= 1'b0;
            latMode   <= 2'd0;
            latAddr   <= 32'd0;
            latWdata  <= 32'd0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
        end else if (grant) begin
            owner     <= winner;
            lastOwner <= winner;
            cnt       <= CNT_INIT;
            latWrite  <= winner ? m1_write : m0_write;
            latMode   <= winner ? m1_mode  : m0_mode;
            latAddr   <= winner ? m1_addr  : m0_addr;
            latWdata  <= winner ? m1_wdata : m0_wdata;
        end else if (state == ACCESS) begin
            if (cnt != 4'd0)
                cnt <= cnt - 4'd1;
            else if (owner)
                m1_rdata <= latWrite ? 32'd0 : mem_readData;
            else
                m0_rdata <= latWrite ? 32'd0 : mem_readData;
        end
    end

`ifdef ARB_STATS_EN
    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_m0_grants <= 16'd0;
            stat_m1_grants <= 16'd0;
            stat_conflicts <= 16'd0;
        end else if (grant) begin
            if (winner)
                stat_m1_grants <= satInc(stat_m1_grants);
            else
                stat_m0_grants <= satInc(stat_m0_grants);
            if (bothReq)
                stat_conflicts <= satInc(stat_conflicts);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance A (1 cycle, round-robin) with a word memory,
// B (4 cycles, round-robin) and C (1 cycle, fixed priority) sharing the same requester stimulus.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        memInit;
    logic        m0Req, m0Write, m1Req, m1Write;
    logic [1:0]  m0Mode, m1Mode;
    logic [31:0] m0Addr, m0Wdata, m1Addr, m1Wdata;

    logic        aM0Ready, aM1Ready, aMemRead, aMemWrite, aBusy, aOwner;
    logic [31:0] aM0Rdata, aM1Rdata, aMemAddress, aMemWriteData, aMemReadData;
    logic [1:0]  aMemMode;
    logic        bM0Ready, bM1Ready, bMemRead, bMemWrite, bBusy, bOwner;
    logic [31:0] bM0Rdata, bM1Rdata, bMemAddress, bMemWriteData, bMemReadData;
    logic [1:0]  bMemMode;
    logic        cM0Ready, cM1Ready, cMemRead, cMemWrite, cBusy, cOwner;
    logic [31:0] cM0Rdata, cM1Rdata, cMemAddress, cMemWriteData, cMemReadData;
    logic [1:0]  cMemMode;
`ifdef ARB_STATS_EN
    logic [15:0] aStM0, aStM1, aStCf, bStM0, bStM1, bStCf, cStM0, cStM1, cStCf;
`endif

    logic [31:0] memA [0:63];
    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 64; i++) memA[i] <= 32'd0;
            memA[4] <= 32'hDEADBEEF;
        end else if (aMemWrite) begin
            memA[aMemAddress[7:2]] <= aMemWriteData;
        end
    end
    assign aMemReadData = memA[aMemAddress[7:2]];
    assign bMemReadData = bMemAddress ^ 32'h5A5A5A5A;
    assign cMemReadData = cMemAddress ^ 32'h5A5A5A5A;

    dmem_arbiter #(.ACCESS_CYCLES(1), .FIXED_PRIORITY(0)) dutA (
        .clk(clk), .reset(reset),
        .m0_req(m0Req), .m0_write(m0Write), .m0_mode(m0Mode), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
        .m0_ready(aM0Ready), .m0_rdata(aM0Rdata),
        .m1_req(m1Req), .m1_write(m1Write), .m1_mode(m1Mode), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
        .m1_ready(aM1Ready), .m1_rdata(aM1Rdata),
        .mem_address(aMemAddress), .mem_writeData(aMemWriteData), .mem_mode(aMemMode),
        .mem_memRead(aMemRead), .mem_memWrite(aMemWrite), .mem_readData(aMemReadData),
        .busy(aBusy), .owner(aOwner)
`ifdef ARB_STATS_EN
        , .stat_m0_grants(aStM0), .stat_m1_grants(aStM1), .stat_conflicts(aStCf)
`endif
    );

    dmem_arbiter #(.ACCESS_CYCLES(4), .FIXED_PRIORITY(0)) dutB (
        .clk(clk), .reset(reset),
        .m0_req(m0Req), .m0_write(m0Write), .m0_mode(m0Mode), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
        .m0_ready(bM0Ready), .m0_rdata(bM0Rdata),
        .m1_req(m1Req), .m1_write(m1Write), .m1_mode(m1Mode), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
        .m1_ready(bM1Ready), .m1_rdata(bM1Rdata),
        .mem_address(bMemAddress), .mem_writeData(bMemWriteData), .mem_mode(bMemMode),
        .mem_memRead(bMemRead), .mem_memWrite(bMemWrite), .mem_readData(bMemReadData),
        .busy(bBusy), .owner(bOwner)
`ifdef ARB_STATS_EN
        , .stat_m0_grants(bStM0), .stat_m1_grants(bStM1), .stat_conflicts(bStCf)
`endif
    );

    dmem_arbiter #(.ACCESS_CYCLES(1), .FIXED_PRIORITY(1)) dutC (
        .clk(clk), .reset(reset),
        .m0_req(m0Req), .m0_write(m0Write), .m0_mode(m0Mode), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
        .m0_ready(cM0Ready), .m0_rdata(cM0Rdata),
        .m1_req(m1Req), .m1_write(m1Write), .m1_mode(m1Mode), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
        .m1_ready(cM1Ready), .m1_rdata(cM1Rdata),
        .mem_address(cMemAddress), .mem_writeData(cMemWriteData), .mem_mode(cMemMode),
        .mem_memRead(cMemRead), .mem_memWrite(cMemWrite), .mem_readData(cMemReadData),
        .busy(cBusy), .owner(cOwner)
`ifdef ARB_STATS_EN
        , .stat_m0_grants(cStM0), .stat_m1_grants(cStM1), .stat_conflicts(cStCf)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        m0Req = 1'b0; m0Write = 1'b0; m0Mode = 2'd0; m0Addr = 32'd0; m0Wdata = 32'd0;
        m1Req = 1'b0; m1Write = 1'b0; m1Mode = 2'd0; m1Addr = 32'd0; m1Wdata = 32'd0;
    endtask

    task automatic resetAll();
        clearInputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        resetAll();
        checks++;
        if ({aBusy, aOwner, aM0Ready, aM1Ready, aMemRead, aMemWrite} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl_a got=%b exp=000000", {aBusy, aOwner, aM0Ready, aM1Ready, aMemRead, aMemWrite});
        end
        checks++;
        if ({aM0Rdata, aM1Rdata, aMemAddress, aMemWriteData, aMemMode} !== 130'd0) begin
            failures++;
            $display("FAIL reset_data_a got=%h/%h/%h/%h/%b exp=all zero", aM0Rdata, aM1Rdata, aMemAddress, aMemWriteData, aMemMode);
        end
        checks++;
        if ({bBusy, bOwner, cBusy, cOwner, bM0Rdata, cM1Rdata} !== 68'd0) begin
            failures++;
            $display("FAIL reset_bc got=%b%b%b%b %h %h exp=zero", bBusy, bOwner, cBusy, cOwner, bM0Rdata, cM1Rdata);
        end
`ifdef ARB_STATS_EN
        checks++;
        if ({aStM0, aStM1, aStCf} !== 48'd0) begin
            failures++;
            $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", aStM0, aStM1, aStCf);
        end
`endif
    endtask

    task automatic test_single_load();
        resetAll();
        m0Req = 1'b1; m0Write = 1'b0; m0Mode = 2'b10; m0Addr = 32'h10;
        step();
        checks++;
        if ({aMemRead, aMemWrite, aBusy, aM0Ready, aM1Ready} !== 5'b10100) begin
            failures++;
            $display("FAIL load_access_ctrl got=%b exp=10100", {aMemRead, aMemWrite, aBusy, aM0Ready, aM1Ready});
        end
        checks++;
        if (aMemAddress !== 32'h10 || aMemMode !== 2'b10) begin
            failures++;
            $display("FAIL load_access_addr got=%h mode=%b exp=00000010 mode=10", aMemAddress, aMemMode);
        end
        step();
        checks++;
        if ({aM0Ready, aM1Ready, aMemRead, aBusy} !== 4'b1001) begin
            failures++;
            $display("FAIL load_resp_ctrl got=%b exp=1001", {aM0Ready, aM1Ready, aMemRead, aBusy});
        end
        checks++;
        if (aM0Rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_rdata got=%h exp=deadbeef", aM0Rdata);
        end
        m0Req = 1'b0;
        step();
        checks++;
        if ({aBusy, aM0Ready, aOwner} !== 3'b000 || aM0Rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_idle_hold got=%b %h exp=000 deadbeef", {aBusy, aM0Ready, aOwner}, aM0Rdata);
        end
    endtask

    task automatic test_single_store();
        resetAll();
        m1Req = 1'b1; m1Write = 1'b1; m1Mode = 2'b11; m1Addr = 32'h20; m1Wdata = 32'h12345678;
        step();
        checks++;
        if ({aMemRead, aMemWrite, aBusy, aOwner} !== 4'b0111) begin
            failures++;
            $display("FAIL store_access_ctrl got=%b exp=0111", {aMemRead, aMemWrite, aBusy, aOwner});
        end
        checks++;
        if (aMemAddress !== 32'h20 || aMemWriteData !== 32'h12345678 || aMemMode !== 2'b11) begin
            failures++;
            $display("FAIL store_access_fields got=%h %h %b exp=00000020 12345678 11", aMemAddress, aMemWriteData, aMemMode);
        end
        step();
        checks++;
        if ({aM1Ready, aM0Ready, aMemWrite, aMemRead} !== 4'b1000 || aM1Rdata !== 32'd0) begin
            failures++;
            $display("FAIL store_resp got=%b rdata=%h exp=1000 rdata=0", {aM1Ready, aM0Ready, aMemWrite, aMemRead}, aM1Rdata);
        end
        m1Req = 1'b0; m1Write = 1'b0;
        step();
        m0Req = 1'b1; m0Write = 1'b0; m0Addr = 32'h20;
        step();
        step();
        checks++;
        if (aM0Ready !== 1'b1 || aM0Rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL store_readback got=%b %h exp=1 12345678", aM0Ready, aM0Rdata);
        end
        m0Req = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        resetAll();
        m0Req = 1'b1; m0Addr = 32'h10;
        m1Req = 1'b1; m1Addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (aBusy !== 1'b1 || aMemRead !== 1'b1) begin
                failures++;
                $display("FAIL rr_access%0d got=%b%b exp=11", k, aBusy, aMemRead);
            end
            step();
            checks++;
            if ({aM0Ready, aM1Ready, aOwner} !== ((k % 2 == 0) ? 3'b100 : 3'b011)) begin
                failures++;
                $display("FAIL rr_resp%0d got=%b exp=%b", k, {aM0Ready, aM1Ready, aOwner}, (k % 2 == 0) ? 3'b100 : 3'b011);
            end
            checks++;
            if ((k % 2 == 0) ? (aM0Rdata !== 32'hDEADBEEF) : (aM1Rdata !== 32'h12345678)) begin
                failures++;
                $display("FAIL rr_rdata%0d got=%h/%h exp=deadbeef/12345678", k, aM0Rdata, aM1Rdata);
            end
            checks++;
            if ({cM0Ready, cM1Ready, cOwner} !== 3'b100) begin
                failures++;
                $display("FAIL fixed_resp%0d got=%b exp=100", k, {cM0Ready, cM1Ready, cOwner});
            end
            step();
            checks++;
            if (aBusy !== 1'b0 || aM0Ready !== 1'b0 || aM1Ready !== 1'b0) begin
                failures++;
                $display("FAIL rr_idle%0d got=%b%b%b exp=000", k, aBusy, aM0Ready, aM1Ready);
            end
        end
        clearInputs();
        step();
    endtask

    task automatic test_multicycle();
        resetAll();
        m0Req = 1'b1; m0Write = 1'b1; m0Mode = 2'b01; m0Addr = 32'h40; m0Wdata = 32'hA5A50F0F;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if ({bMemRead, bMemWrite, bBusy, bM0Ready} !== {1'b0, (i == 4), 1'b1, 1'b0} || bMemAddress !== 32'h40) begin
                failures++;
                $display("FAIL multi_access%0d got=%b addr=%h exp=0%0d10 addr=00000040", i, {bMemRead, bMemWrite, bBusy, bM0Ready}, bMemAddress, (i == 4));
            end
        end
        step();
        checks++;
        if ({bM0Ready, bM1Ready, bMemWrite} !== 3'b100 || bM0Rdata !== 32'd0) begin
            failures++;
            $display("FAIL multi_resp got=%b rdata=%h exp=100 rdata=0", {bM0Ready, bM1Ready, bMemWrite}, bM0Rdata);
        end
        m0Req = 1'b0;
        step();
        checks++;
        if (bBusy !== 1'b0) begin
            failures++;
            $display("FAIL multi_idle got=%b exp=0", bBusy);
        end
    endtask

    task automatic test_reset_mid_access();
        resetAll();
        m0Req = 1'b1; m0Write = 1'b1; m0Addr = 32'h44; m0Wdata = 32'h0BADF00D;
        step();
        step();
        reset = 1'b1;
        m0Req = 1'b0;
        checks++;
        if (bBusy !== 1'b1 || bMemWrite !== 1'b0) begin
            failures++;
            $display("FAIL midrst_before got=%b%b exp=10", bBusy, bMemWrite);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bBusy, bM0Ready, bM1Ready, bMemWrite, bMemRead} !== 5'b0) begin
                failures++;
                $display("FAIL midrst_after%0d got=%b exp=00000", i, {bBusy, bM0Ready, bM1Ready, bMemWrite, bMemRead});
            end
            step();
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        resetAll();
        m0Req = 1'b1; m0Addr = 32'h10;
        m1Req = 1'b1; m1Addr = 32'h20;
        for (int k = 0; k < 5; k++) begin
            step();
            step();
            if (k == 2) m1Req = 1'b0;
            if (k == 4) m0Req = 1'b0;
            step();
        end
        checks++;
        if (aStM0 !== 16'd4 || aStM1 !== 16'd1 || aStCf !== 16'd3) begin
            failures++;
            $display("FAIL stats got=%0d/%0d/%0d exp=4/1/3", aStM0, aStM1, aStCf);
        end
        clearInputs();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        memInit  = 1'b1;
        clearInputs();
        resetAll();
        memInit = 1'b0;
        test_reset();
        test_single_load();
        test_single_store();
        test_round_robin();
        test_multicycle();
        test_reset_mid_access();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
